parking_timer: RTL and testbench
================================

Name: parking_timer

Overview:
Multi-slot parking duration timer; successor to the single free-running 0..999 counter. One shared prescaler generates a time-base tick. NUM_SLOTS independent per-slot counters count ticks from start to stop and flag expiry at a programmable limit. Sits between the gate/slot-sensor controller (issues start/stop) and the fee/display logic (reads counts and expiry).

Parameters:
NUM_SLOTS, 4, number of independent parking slots (>=1)
CNT_W, 10, per-slot count width in bits
TICK_DIV, 1000, clk cycles per time-base tick (>=1)
LIMIT, 999, tick count at which a slot expires (1 <= LIMIT <= 2^CNT_W-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  NUM_SLOTS  per-slot start/restart request, one-cycle pulse
stop  in  NUM_SLOTS  per-slot stop request, one-cycle pulse
tick  out  1  one-cycle time-base pulse
count  out  NUM_SLOTS*CNT_W  packed counts, slot i at bits [i*CNT_W +: CNT_W]
running  out  NUM_SLOTS  slot in RUN
expired  out  NUM_SLOTS  slot in EXPIRED (level)
expired_pulse  out  NUM_SLOTS  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (sync, active-high, sampled on clk rising edge): prescaler=0, every slot IDLE, all outputs 0. Reset asserted mid-count aborts all slots immediately.
- Prescaler: div counts 0..TICK_DIV-1 and wraps. tick=1 (registered) in the cycle after div==TICK_DIV-1, so there is one tick per TICK_DIV cycles. TICK_DIV=1 gives tick every cycle. Free-running, unaffected by slot activity.
- Per-slot FSM states: IDLE, RUN, EXPIRED. Per-slot priority: stop > start > tick.
- IDLE: start -> RUN, count<=0. Otherwise count holds its last value, so the parked duration stays readable after stop.
- RUN: stop -> IDLE, count held. start -> count<=0, stay RUN. tick -> count<=count+1; if count+1==LIMIT -> EXPIRED and expired_pulse=1 for one cycle.
- EXPIRED: count holds LIMIT and ticks are ignored (saturates, no wrap). stop -> IDLE, count held. start -> RUN, count<=0, expired clears.
- Simultaneous start+stop on the same slot: slot goes IDLE and count is not cleared. Stop coinciding with tick: no increment. Start coinciding with tick: count=0.
- Latency: a request sampled at edge n is visible on running/expired/count after edge n. The first increment happens on the first tick strictly after start.
- All outputs are registered. Slots are fully independent.

Optional Feature:
PARKING_TIMER_PAUSE_EN
- Defined: adds input pause [NUM_SLOTS] (level) and output paused [NUM_SLOTS]. In RUN with pause=1, ticks are ignored, running stays 1, and paused=1. Priority becomes stop > start > pause > tick. pause is ignored in IDLE and EXPIRED. paused resets to 0.
- Undefined: both ports are absent and behaviour equals pause tied 0.

Decomposition:
- Package parking_timer_pkg holds the slot state encoding (IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10) and default constants for CNT_W, TICK_DIV and LIMIT.
- Sub-module parking_slot_timer holds one slot's FSM, counter and pulse. It is instantiated NUM_SLOTS times via generate. The prescaler stays inline in parking_timer.

Test Plan:
All tests use NUM_SLOTS=2, CNT_W=4, TICK_DIV=4, LIMIT=5.
1. Reset mid-run at count=3 for 2 cycles -> all outputs 0; the first tick comes 4 cycles after reset deasserts.
2. start[0] then no stop -> count[0] goes 1,2,3,4,5 on successive ticks; expired[0]=1 and expired_pulse[0] pulses once on reaching 5; count stays 5 across 3 more ticks.
3. start[0], stop[0] after 3 ticks -> running[0]=0, count[0]=3 held for 4 further ticks; a new start[0] gives count[0]=0 and running[0]=1.
4. start[1] and stop[1] in the same cycle -> IDLE with count unchanged. stop[0] coinciding with tick at count=2 -> count stays 2.
5. start[1] 2 ticks after start[0] -> expired[1] rises exactly 8 cycles after expired[0]. start[0] while EXPIRED -> expired[0]=0 and count[0]=0.
6. With PARKING_TIMER_PAUSE_EN: pause[0] held for 3 ticks at count 2 -> count stays 2 and paused[0]=1; expiry occurs 12 cycles later than in the unpaused run.

Source files
------------

// File: rtl/parking_timer_pkg.sv
// ============================================================================
// parking_timer_pkg : slot state encoding and default constants
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package parking_timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      EXPIRED = 2'b10
   } slot_state_t;

   localparam int DEF_CNT_W    = 10;
   localparam int DEF_TICK_DIV = 1000;
   localparam int DEF_LIMIT    = 999;

endpackage

`default_nettype wire

// File: rtl/parking_slot_timer.sv
// ============================================================================
// parking_slot_timer : one slot's IDLE/RUN/EXPIRED FSM with saturating counter
// Optional macro: PARKING_TIMER_PAUSE_EN (adds pause input / paused output)
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module parking_slot_timer
   import parking_timer_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int LIMIT = DEF_LIMIT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             tick,
`ifdef PARKING_TIMER_PAUSE_EN
   input  logic             pause,
   output logic             paused,
`endif
   output logic [CNT_W-1:0] count,
   output logic             running,
   output logic             expired,
   output logic             expired_pulse
);

   localparam logic [CNT_W-1:0] LAST_BEFORE_LIMIT = CNT_W'(LIMIT - 1);

   slot_state_t state;
   logic        hold;

`ifdef PARKING_TIMER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         running       <= 1'b0;
         expired       <= 1'b0;
         expired_pulse <= 1'b0;
`ifdef PARKING_TIMER_PAUSE_EN
         paused        <= 1'b0;
`endif
      end else begin
         expired_pulse <= 1'b0;
`ifdef PARKING_TIMER_PAUSE_EN
         paused        <= 1'b0;
`endif
         case (state)
            RUN: begin
               if (stop) begin
                  state   <= IDLE;
                  running <= 1'b0;
               end else if (start) begin
                  count <= '0;
               end else if (hold) begin
`ifdef PARKING_TIMER_PAUSE_EN
                  paused <= 1'b1;
`endif
               end else if (tick) begin
                  count <= count + CNT_W'(1);
                  if (count == LAST_BEFORE_LIMIT) begin
                     state         <= EXPIRED;
                     running       <= 1'b0;
                     expired       <= 1'b1;
                     expired_pulse <= 1'b1;
                  end
               end
            end
            EXPIRED: begin
               // Count sits at LIMIT here; ticks are ignored so it saturates.
               if (stop) begin
                  state   <= IDLE;
                  expired <= 1'b0;
               end else if (start) begin
                  state   <= RUN;
                  count   <= '0;
                  running <= 1'b1;
                  expired <= 1'b0;
               end
            end
            default: begin
               if (!stop && start) begin
                  state   <= RUN;
                  count   <= '0;
                  running <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/parking_timer.sv
// ============================================================================
// parking_timer : shared tick prescaler driving NUM_SLOTS parking slot timers
// Optional macro: PARKING_TIMER_PAUSE_EN (per-slot pause / paused ports)
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module parking_timer
   import parking_timer_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int LIMIT     = DEF_LIMIT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_SLOTS-1:0]       start,
   input  logic [NUM_SLOTS-1:0]       stop,
`ifdef PARKING_TIMER_PAUSE_EN
   input  logic [NUM_SLOTS-1:0]       pause,
   output logic [NUM_SLOTS-1:0]       paused,
`endif
   output logic                       tick,
   output logic [NUM_SLOTS*CNT_W-1:0] count,
   output logic [NUM_SLOTS-1:0]       running,
   output logic [NUM_SLOTS-1:0]       expired,
   output logic [NUM_SLOTS-1:0]       expired_pulse
);

   localparam int               DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div;

   // Free-running prescaler; tick is registered one cycle after the wrap value.
   always_ff @(posedge clk) begin
      if (reset) begin
         div  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (div == DIV_LAST);
         div  <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      end
   end

   generate
      for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
         parking_slot_timer #(
            .CNT_W (CNT_W),
            .LIMIT (LIMIT)
         ) u_slot (
            .clk           (clk),
            .reset         (reset),
            .start         (start[i]),
            .stop          (stop[i]),
            .tick          (tick),
`ifdef PARKING_TIMER_PAUSE_EN
            .pause         (pause[i]),
            .paused        (paused[i]),
`endif
            .count         (count[i*CNT_W +: CNT_W]),
            .running       (running[i]),
            .expired       (expired[i]),
            .expired_pulse (expired_pulse[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_parking_timer.sv
// ============================================================================
// tb_parking_timer : directed stimulus with queued expectations and a monitor
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_parking_timer;

   localparam int NS = 2;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NS-1:0]   start = '0;
   logic [NS-1:0]   stop = '0;
   logic [NS-1:0]   pause = '0;
   logic [NS-1:0]   paused;
   logic            tick;
   logic [NS*CW-1:0] count;
   logic [NS-1:0]   running;
   logic [NS-1:0]   expired;
   logic [NS-1:0]   expired_pulse;

   parking_timer #(
      .NUM_SLOTS (NS),
      .CNT_W     (CW),
      .TICK_DIV  (4),
      .LIMIT     (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stop          (stop),
`ifdef PARKING_TIMER_PAUSE_EN
      .pause         (pause),
      .paused        (paused),
`endif
      .tick          (tick),
      .count         (count),
      .running       (running),
      .expired       (expired),
      .expired_pulse (expired_pulse)
   );

`ifndef PARKING_TIMER_PAUSE_EN
   assign paused = '0;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // sel: 0 count[slot], 1 running, 2 expired, 3 expired_pulse, 4 tick, 5 paused
   typedef struct {
      string       name;
      int          at;
      int          sel;
      int          slot;
      logic [31:0] exp;
   } chk_t;

   typedef struct {
      int            at;
      logic [NS-1:0] mask;
   } pe_t;

   chk_t snap_q[$];
   pe_t  pulse_q[$];
   int   compared = 0;
   int   mismatched = 0;

   task automatic expect_at(input string n, input int at, input int sel,
                            input int slot, input logic [31:0] e);
      chk_t c;
      c.name = n; c.at = at; c.sel = sel; c.slot = slot; c.exp = e;
      snap_q.push_back(c);
   endtask

   task automatic expect_pulse(input int at, input logic [NS-1:0] m);
      pe_t p;
      p.at = at; p.mask = m;
      pulse_q.push_back(p);
   endtask

   function automatic logic [31:0] field(input int sel, input int slot);
      case (sel)
         0:       return 32'(count[slot*CW +: CW]);
         1:       return 32'(running);
         2:       return 32'(expired);
         3:       return 32'(expired_pulse);
         4:       return 32'(tick);
         default: return 32'(paused);
      endcase
   endfunction

   // Monitor: snapshot checks due this cycle, plus every expired_pulse event.
   always @(negedge clk) begin
      for (int i = snap_q.size() - 1; i >= 0; i--) begin
         if (snap_q[i].at <= cyc) begin
            logic [31:0] act;
            act = field(snap_q[i].sel, snap_q[i].slot);
            compared++;
            if (snap_q[i].at != cyc || act !== snap_q[i].exp) begin
               mismatched++;
               $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                        snap_q[i].name, cyc, act, snap_q[i].exp);
            end
            snap_q.delete(i);
         end
      end
      while (pulse_q.size() > 0 && pulse_q[0].at < cyc) begin
         compared++;
         mismatched++;
         $display("FAIL pulse_missing: got none, expected mask %b at cyc %0d",
                  pulse_q[0].mask, pulse_q[0].at);
         void'(pulse_q.pop_front());
      end
      if (expired_pulse !== '0) begin
         compared++;
         if (pulse_q.size() == 0) begin
            mismatched++;
            $display("FAIL pulse_unexpected: got mask %b at cyc %0d, expected none",
                     expired_pulse, cyc);
         end else begin
            pe_t p;
            p = pulse_q.pop_front();
            if (p.at != cyc || p.mask !== expired_pulse) begin
               mismatched++;
               $display("FAIL pulse: got mask %b at cyc %0d, expected mask %b at cyc %0d",
                        expired_pulse, cyc, p.mask, p.at);
            end
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_in(input logic [NS-1:0] s, input logic [NS-1:0] p);
      start = s;
      stop  = p;
      @(negedge clk);
      start = '0;
      stop  = '0;
   endtask

   int r0, r1, r2;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      r0 = cyc;

      // Reset mid-run at count 3; tick returns 4 cycles after release.
      expect_at("t1_count_before_reset", r0 + 13, 0, 0, 3);
      pulse_in(2'b01, 2'b00);
      wait_cyc(r0 + 13);
      reset = 1'b1;
      expect_at("t1_rst_count0", r0 + 14, 0, 0, 0);
      expect_at("t1_rst_running", r0 + 14, 1, 0, 0);
      expect_at("t1_rst_expired", r0 + 14, 2, 0, 0);
      expect_at("t1_rst_tick", r0 + 14, 4, 0, 0);
      expect_at("t1_rst_paused", r0 + 14, 5, 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      r1 = cyc;
      for (int k = 1; k <= 3; k++) expect_at("t1_tick_low", r1 + k, 4, 0, 0);
      expect_at("t1_first_tick", r1 + 4, 4, 0, 1);
      expect_at("t1_tick_one_cycle", r1 + 5, 4, 0, 0);

      // Count up to LIMIT, expire, then saturate.
      pulse_in(2'b01, 2'b00);
      expect_at("t2_running", r1 + 1, 1, 0, 2'b01);
      expect_at("t2_count_pre", r1 + 4, 0, 0, 0);
      for (int k = 1; k <= 5; k++) expect_at("t2_count", r1 + 1 + 4*k, 0, 0, 32'(k));
      expect_pulse(r1 + 21, 2'b01);
      expect_at("t2_not_expired", r1 + 20, 2, 0, 2'b00);
      expect_at("t2_expired", r1 + 21, 2, 0, 2'b01);
      expect_at("t2_running_off", r1 + 21, 1, 0, 2'b00);
      expect_at("t2_pulse_low", r1 + 22, 3, 0, 2'b00);
      expect_at("t2_saturate", r1 + 33, 0, 0, 5);
      expect_at("t2_still_expired", r1 + 33, 2, 0, 2'b01);

      // Stop from EXPIRED, then start, stop after 3 ticks, hold, restart.
      wait_cyc(r1 + 33);
      pulse_in(2'b00, 2'b01);
      expect_at("t3_stop_exp_clear", r1 + 34, 2, 0, 2'b00);
      expect_at("t3_stop_exp_count", r1 + 34, 0, 0, 5);
      pulse_in(2'b01, 2'b00);
      expect_at("t3_count_restart", r1 + 35, 0, 0, 0);
      expect_at("t3_count_3", r1 + 45, 0, 0, 3);
      wait_cyc(r1 + 45);
      pulse_in(2'b00, 2'b01);
      expect_at("t3_stopped", r1 + 46, 1, 0, 2'b00);
      expect_at("t3_held", r1 + 46, 0, 0, 3);
      expect_at("t3_held_later", r1 + 62, 0, 0, 3);
      wait_cyc(r1 + 62);
      pulse_in(2'b01, 2'b00);
      expect_at("t3_restart_count", r1 + 63, 0, 0, 0);
      expect_at("t3_restart_running", r1 + 63, 1, 0, 2'b01);

      // Stop coinciding with tick at count 2.
      expect_at("t4_count_2", r1 + 71, 0, 0, 2);
      wait_cyc(r1 + 72);
      pulse_in(2'b00, 2'b01);
      expect_at("t4_stop_tick_count", r1 + 73, 0, 0, 2);
      expect_at("t4_stop_tick_run", r1 + 73, 1, 0, 2'b00);
      expect_at("t4_stop_tick_later", r1 + 78, 0, 0, 2);

      // Simultaneous start+stop on slot 1 with a nonzero count.
      wait_cyc(r1 + 78);
      pulse_in(2'b10, 2'b00);
      expect_at("t4_s1_count", r1 + 85, 0, 1, 2);
      wait_cyc(r1 + 86);
      pulse_in(2'b10, 2'b10);
      expect_at("t4_both_count", r1 + 87, 0, 1, 2);
      expect_at("t4_both_idle", r1 + 87, 1, 0, 2'b00);
      expect_at("t4_both_later", r1 + 90, 0, 1, 2);

      // Staggered expiry (8 cycles apart), then restart from EXPIRED.
      wait_cyc(r1 + 90);
      pulse_in(2'b01, 2'b00);
      expect_at("t5_c0_zero", r1 + 92, 0, 0, 0);
      expect_at("t5_c0_one", r1 + 93, 0, 0, 1);
      wait_cyc(r1 + 98);
      pulse_in(2'b10, 2'b00);
      expect_pulse(r1 + 109, 2'b01);
      expect_pulse(r1 + 117, 2'b10);
      expect_at("t5_exp0", r1 + 109, 2, 0, 2'b01);
      expect_at("t5_exp0_only", r1 + 116, 2, 0, 2'b01);
      expect_at("t5_exp_both", r1 + 117, 2, 0, 2'b11);
      expect_at("t5_run_none", r1 + 117, 1, 0, 2'b00);
      wait_cyc(r1 + 118);
      pulse_in(2'b01, 2'b00);
      expect_at("t5_restart_exp", r1 + 119, 2, 0, 2'b10);
      expect_at("t5_restart_cnt", r1 + 119, 0, 0, 0);
      expect_at("t5_restart_run", r1 + 119, 1, 0, 2'b01);
      expect_at("t5_c1_sat", r1 + 119, 0, 1, 5);
      wait_cyc(r1 + 120);

`ifdef PARKING_TIMER_PAUSE_EN
      // Pause for 3 ticks at count 2 delays expiry by 12 cycles.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      r2 = cyc;
      pulse_in(2'b01, 2'b00);
      expect_at("t6_count_2", r2 + 9, 0, 0, 2);
      wait_cyc(r2 + 9);
      pause = 2'b01;
      expect_at("t6_paused", r2 + 10, 5, 0, 2'b01);
      expect_at("t6_running", r2 + 15, 1, 0, 2'b01);
      expect_at("t6_count_hold", r2 + 21, 0, 0, 2);
      wait_cyc(r2 + 21);
      pause = 2'b00;
      expect_at("t6_unpaused", r2 + 22, 5, 0, 2'b00);
      expect_at("t6_count_3", r2 + 25, 0, 0, 3);
      expect_pulse(r2 + 33, 2'b01);
      expect_at("t6_not_yet", r2 + 32, 2, 0, 2'b00);
      expect_at("t6_expired", r2 + 33, 2, 0, 2'b01);
      wait_cyc(r2 + 36);
`else
      r2 = cyc;
`endif

      wait_cyc(cyc + 10);
      if (snap_q.size() != 0 || pulse_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL leftover_expectations: got %0d pending, expected 0",
                  snap_q.size() + pulse_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      mismatched++;
      $display("FAIL watchdog: got timeout at cyc %0d, expected completion", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
